// File: rtl/gmii_frame_checker_pkg.sv
// -----------------------------------------------------------------------------
// gmii_frame_checker_pkg
//   Shared types and constants for the GMII receive frame checker:
//   FSM state encoding, preamble/SFD byte values, CRC-32 constants and a
//   32-bit bit-reverse helper used to move between reflected and normal
//   CRC register orderings.
// -----------------------------------------------------------------------------
package gmii_frame_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP,
        END
    } state_t;

    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    // Magic residue of a good frame, in normal (MSB-first) bit order.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // Width of the frame length counter; holds C_MAX_FRAME_LEN+1.
    localparam int          LEN_W         = 11;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_crc32_byte.sv
// -----------------------------------------------------------------------------
// gmii_crc32_byte
//   Combinational byte-serial CRC-32 step, reflected (LSB-first) form as used
//   by Ethernet. No inversion is applied here; the caller owns init/final.
//
// Ports:
//   crc      in  32  current CRC register
//   d        in   8  data byte, bit 0 first on the wire
//   crc_next out 32  CRC register after absorbing d
// -----------------------------------------------------------------------------
module gmii_crc32_byte
    import gmii_frame_checker_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  d,
    output logic [31:0] crc_next
);

    localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

    always_comb begin
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/gmii_frame_checker.sv
// -----------------------------------------------------------------------------
// gmii_frame_checker
//   Receive-side GMII frame checker. Registers the GMII stream once, strips
//   preamble/SFD, counts post-SFD bytes (FCS included), classifies each frame
//   (error / runt / long / FCS / good), timestamps the SFD against sec/nsec
//   and keeps saturating statistics counters.
//
//   Optional build macro: GMII_FRAME_CHECKER_FCS_CHECK_EN
//     defined   -> CRC-32 over all DATA bytes, bad residue counted in
//                  fcs_err_cnt and excluded from frame_ok.
//     undefined -> no CRC logic, fcs_err_cnt tied to 0.
//
// Ports:
//   clk, resetn          core clock, asynchronous active-low reset
//   clear                synchronous clear of all statistics counters
//   gmii_d/en/er         GMII receive data, data valid, receive error
//   sec, nsec            time of day
//   frame_done           1-cycle pulse at end of each frame
//   frame_ok             good-frame status, valid with frame_done
//   last_len             post-SFD byte count of the last frame
//   last_sec, last_nsec  time of day sampled with the SFD of the last frame
//   frames_cnt, bytes_cnt, err_cnt, runt_cnt, long_cnt, fcs_err_cnt
//                        saturating statistics
// -----------------------------------------------------------------------------
module gmii_frame_checker
    import gmii_frame_checker_pkg::*;
#(
    parameter int C_MIN_FRAME_LEN = 64,
    parameter int C_MAX_FRAME_LEN = 1518,
    parameter int C_CNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic [7:0]             gmii_d,
    input  logic                   gmii_en,
    input  logic                   gmii_er,
    input  logic [47:0]            sec,
    input  logic [29:0]            nsec,
    output logic                   frame_done,
    output logic                   frame_ok,
    output logic [LEN_W-1:0]       last_len,
    output logic [47:0]            last_sec,
    output logic [29:0]            last_nsec,
    output logic [C_CNT_WIDTH-1:0] frames_cnt,
    output logic [C_CNT_WIDTH-1:0] bytes_cnt,
    output logic [C_CNT_WIDTH-1:0] err_cnt,
    output logic [C_CNT_WIDTH-1:0] runt_cnt,
    output logic [C_CNT_WIDTH-1:0] long_cnt,
    output logic [C_CNT_WIDTH-1:0] fcs_err_cnt
);

    localparam logic [LEN_W-1:0]       LEN_MIN = LEN_W'(C_MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0]       LEN_MAX = LEN_W'(C_MAX_FRAME_LEN);
    localparam logic [LEN_W-1:0]       LEN_CAP = LEN_W'(C_MAX_FRAME_LEN + 1);
    localparam int                     SUM_W   = ((C_CNT_WIDTH > LEN_W) ? C_CNT_WIDTH : LEN_W) + 1;
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [C_CNT_WIDTH-1:0] sat_add(
        input logic [C_CNT_WIDTH-1:0] a,
        input logic [LEN_W-1:0]       b
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return s[C_CNT_WIDTH-1:0];
    endfunction

    // ---- stage p0: registered GMII inputs and time of day ----
    logic [7:0]  d_p0;
    logic        en_p0;
    logic        er_p0;
    logic [47:0] sec_p0;
    logic [29:0] nsec_p0;
    // Set once any sample up to and including en_p0 had gmii_en low. Until
    // then we may be looking at the tail of a frame that straddled reset.
    logic        armed;

    always_ff @(posedge clk) begin
        d_p0    <= gmii_d;
        er_p0   <= gmii_er;
        sec_p0  <= sec;
        nsec_p0 <= nsec;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_p0 <= 1'b0;
            armed <= 1'b0;
        end else begin
            en_p0 <= gmii_en;
            armed <= armed | ~gmii_en;
        end
    end

    // ---- stage p1: frame delineation FSM ----
    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n;
    logic             er_flag, er_flag_n;
    logic             bad_sfd, bad_sfd_n;
    logic             discard, discard_n;
    logic             cap_en;
    logic [47:0]      cap_sec;
    logic [29:0]      cap_nsec;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            len      <= '0;
            er_flag  <= 1'b0;
            bad_sfd  <= 1'b0;
            discard  <= 1'b0;
            cap_sec  <= '0;
            cap_nsec <= '0;
        end else begin
            state   <= state_n;
            len     <= len_n;
            er_flag <= er_flag_n;
            bad_sfd <= bad_sfd_n;
            discard <= discard_n;
            if (cap_en) begin
                cap_sec  <= sec_p0;
                cap_nsec <= nsec_p0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        len_n     = len;
        er_flag_n = er_flag;
        bad_sfd_n = bad_sfd;
        discard_n = discard;
        cap_en    = 1'b0;
        case (state)
            // END doubles as IDLE so a frame may start on the cycle right
            // after the one-cycle inter-frame gap.
            IDLE, END: begin
                state_n = IDLE;
                if (en_p0) begin
                    len_n     = '0;
                    er_flag_n = 1'b0;
                    bad_sfd_n = 1'b0;
                    discard_n = 1'b0;
                    if (!armed) begin
                        state_n   = DROP;
                        discard_n = 1'b1;
                    end else if (d_p0 == GMII_PREAMBLE) begin
                        state_n = PREAMBLE;
                    end else if (d_p0 == GMII_SFD) begin
                        state_n = DATA;
                        cap_en  = 1'b1;
                    end else begin
                        state_n   = DROP;
                        bad_sfd_n = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!en_p0) begin
                    state_n   = END;
                    bad_sfd_n = 1'b1;
                end else if (d_p0 == GMII_SFD) begin
                    state_n = DATA;
                    cap_en  = 1'b1;
                end else if (d_p0 != GMII_PREAMBLE) begin
                    state_n   = DROP;
                    bad_sfd_n = 1'b1;
                end
            end
            DATA: begin
                if (en_p0) begin
                    if (len != LEN_CAP) begin
                        len_n = len + 1'b1;
                    end
                    if (er_p0) begin
                        er_flag_n = 1'b1;
                    end
                end else begin
                    state_n = END;
                end
            end
            DROP: begin
                if (!en_p0) begin
                    state_n = END;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic fcs_bad;

`ifdef GMII_FRAME_CHECKER_FCS_CHECK_EN
    logic [31:0] crc, crc_next;
    logic        crc_init, crc_upd;

    assign crc_init = ((state == IDLE) || (state == END)) && en_p0;
    assign crc_upd  = (state == DATA) && en_p0;

    gmii_crc32_byte u_crc (
        .crc      (crc),
        .d        (d_p0),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc <= '1;
        end else if (crc_init) begin
            crc <= '1;
        end else if (crc_upd) begin
            crc <= crc_next;
        end
    end

    // The register runs reflected; compare in normal bit order.
    assign fcs_bad = (bitrev32(crc) != CRC32_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    // ---- stage p2: classification, status and statistics ----
    logic frame_end;
    logic cls_err, cls_runt, cls_long, cls_good;

    // Frames picked up mid-flight after reset are dropped silently.
    assign frame_end = (state == END) && !discard;

    always_comb begin
        cls_err  = 1'b0;
        cls_runt = 1'b0;
        cls_long = 1'b0;
        if (er_flag || bad_sfd) begin
            cls_err = 1'b1;
        end else if (len < LEN_MIN) begin
            cls_runt = 1'b1;
        end else if (len > LEN_MAX) begin
            cls_long = 1'b1;
        end
        cls_good = !(cls_err || cls_runt || cls_long) && !fcs_bad;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            last_len   <= '0;
            last_sec   <= '0;
            last_nsec  <= '0;
        end else begin
            frame_done <= frame_end;
            frame_ok   <= frame_end && cls_good;
            if (frame_end) begin
                last_len  <= len;
                last_sec  <= cap_sec;
                last_nsec <= cap_nsec;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frames_cnt <= '0;
            bytes_cnt  <= '0;
            err_cnt    <= '0;
            runt_cnt   <= '0;
            long_cnt   <= '0;
        end else if (clear) begin
            frames_cnt <= '0;
            bytes_cnt  <= '0;
            err_cnt    <= '0;
            runt_cnt   <= '0;
            long_cnt   <= '0;
        end else if (frame_end) begin
            if (cls_err)  err_cnt  <= sat_add(err_cnt,  LEN_W'(1));
            if (cls_runt) runt_cnt <= sat_add(runt_cnt, LEN_W'(1));
            if (cls_long) long_cnt <= sat_add(long_cnt, LEN_W'(1));
            if (cls_good) begin
                frames_cnt <= sat_add(frames_cnt, LEN_W'(1));
                bytes_cnt  <= sat_add(bytes_cnt, len);
            end
        end
    end

`ifdef GMII_FRAME_CHECKER_FCS_CHECK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fcs_err_cnt <= '0;
        end else if (clear) begin
            fcs_err_cnt <= '0;
        end else if (frame_end && !(cls_err || cls_runt || cls_long) && fcs_bad) begin
            fcs_err_cnt <= sat_add(fcs_err_cnt, LEN_W'(1));
        end
    end
`else
    assign fcs_err_cnt = '0;
`endif

endmodule
